mem_port_arbiter: RTL and testbench

Shares a single memory port between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage RISC-V core. It issues one transaction at a time, with a fixed MEM-over-IF priority. It returns read data and done pulses to each stage and drives combinational stall flags into the pipeline stall/flush logic. A wait-cycle watchdog turns a hung port into a bus-error response, so the pipeline cannot lock up.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between IF fetch and MEM
// load/store. One transaction in flight at a time, and MEM has priority over IF.
// A wait-cycle watchdog turns a hung port into a bus-error response.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        port_req,
    output logic        port_we,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    output logic [3:0]  port_wstrb,
    input  logic        port_ready,
    input  logic        port_rvalid,
    input  logic [31:0] port_rdata,
    output logic        bus_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t        state, state_nxt;
    owner_t        owner;
    logic          killed;
    logic [CW-1:0] wait_cnt;

    logic load_if, load_mem;   // latch a requester into the port registers
    logic finish;              // transaction resolves this cycle (response or timeout)
    logic tmo_arm;             // watchdog expires at the end of this cycle
    logic kill_now, killed_eff;

    // Stalls come from the registered done pulses and the live requests.
    assign if_stall  = if_req && !if_done;
    assign mem_stall = mem_req && !mem_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle control strobes.
    // bus_err is high for exactly the one cycle in which the watchdog has expired,
    // so it doubles as the "resolve as timeout" condition for ISSUE/WAIT.
    always_comb begin
        state_nxt  = state;
        load_if    = 1'b0;
        load_mem   = 1'b0;
        finish     = 1'b0;
        tmo_arm    = 1'b0;
        kill_now   = if_kill && (owner == OWN_IF) && (state == ISSUE || state == WAIT);
        killed_eff = killed || kill_now;
        case (state)
            IDLE: begin
                if (mem_req)     load_mem = 1'b1;
                else if (if_req) load_if  = 1'b1;
            end
            ISSUE, WAIT: begin
                if (bus_err)                  finish = 1'b1;
                else if (state == WAIT)       finish = port_rvalid;
                else if (port_ready)          state_nxt = WAIT;
                // Arm one cycle early so the bus_err pulse lands on the
                // MAX_WAIT-th cycle counted from the first ISSUE cycle.
                if (!bus_err && !finish && wait_cnt == CW'(MAX_WAIT - 2))
                    tmo_arm = 1'b1;
                if (finish) state_nxt = killed_eff ? IDLE : RESP;
            end
            RESP: begin
                // The requester just served is excluded; it still holds its
                // request this cycle while it sees the done pulse.
                if (owner == OWN_IF && mem_req)      load_mem = 1'b1;
                else if (owner == OWN_MEM && if_req) load_if  = 1'b1;
                else                                 state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (load_if || load_mem) state_nxt = ISSUE;
    end

    // Port registers, owner/kill tracking, watchdog and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            killed     <= 1'b0;
            wait_cnt   <= '0;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_addr  <= '0;
            port_wdata <= '0;
            port_wstrb <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            bus_err  <= tmo_arm;
            if (state == ISSUE || state == WAIT) wait_cnt <= wait_cnt + CW'(1);
            if (kill_now) killed <= 1'b1;
            if ((state == ISSUE && port_ready) || tmo_arm) port_req <= 1'b0;
            // A killed fetch still completes on the port but reports nothing.
            if (finish && !killed_eff) begin
                if (owner == OWN_IF) begin
                    if_done  <= 1'b1;
                    if_rdata <= bus_err ? '0 : port_rdata;
                end else begin
                    mem_done <= 1'b1;
                    if (bus_err)       mem_rdata <= '0;
                    else if (!port_we) mem_rdata <= port_rdata;
                end
            end
            if (load_if) begin
                owner      <= OWN_IF;
                killed     <= 1'b0;
                wait_cnt   <= '0;
                port_req   <= 1'b1;
                port_we    <= 1'b0;
                port_addr  <= if_addr;
                port_wdata <= '0;
                port_wstrb <= '0;
            end
            if (load_mem) begin
                owner      <= OWN_MEM;
                killed     <= 1'b0;
                wait_cnt   <= '0;
                port_req   <= 1'b1;
                port_we    <= mem_we;
                port_addr  <= mem_addr;
                port_wdata <= mem_wdata;
                port_wstrb <= mem_we ? mem_wstrb : 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a delay-programmable memory responder plus a
// transaction-timeline reference model (cycle arithmetic from request time).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_kill = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_done, mem_stall;
    logic        port_req, port_we;
    logic [31:0] port_addr, port_wdata;
    logic [3:0]  port_wstrb;
    logic        port_ready = 1'b0, port_rvalid = 1'b0;
    logic [31:0] port_rdata = '0;
    logic        bus_err;

    int total = 0;
    int bad = 0;
    int ready_dly = 0, rvalid_dly = 0;
    bit hang = 1'b0;
    logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;

    mem_port_arbiter #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_wstrb(port_wstrb),
        .port_ready(port_ready), .port_rvalid(port_rvalid), .port_rdata(port_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by reads.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100)  return 32'h0050_0093;
        if (a == 32'h2000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Memory responder: ready after ready_dly waiting cycles, rvalid
    // rvalid_dly cycles after the first post-accept cycle; never ready if hang.
    int rphase = 0, rcnt = 0;
    logic [31:0] racc_addr = '0;
    logic racc_we = 1'b0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            port_ready = 1'b0; port_rvalid = 1'b0; port_rdata = '0; rphase = 0; rcnt = 0;
        end else begin
            port_ready = 1'b0; port_rvalid = 1'b0;
            if (rphase == 0) begin
                if (port_req && !hang) begin
                    if (rcnt >= ready_dly) begin
                        port_ready = 1'b1; rphase = 1; rcnt = 0;
                        racc_addr = port_addr; racc_we = port_we;
                    end else rcnt++;
                end else rcnt = 0;
            end else begin
                if (rcnt >= rvalid_dly) begin
                    port_rvalid = 1'b1;
                    port_rdata = racc_we ? 32'hBAD0_0000 : mem_word(racc_addr);
                    rphase = 0; rcnt = 0;
                end else rcnt++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({port_req, port_we, port_addr, port_wdata, port_wstrb, if_rdata, mem_rdata,
             if_done, mem_done, bus_err, if_stall, mem_stall} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h ws=%h ird=%h mrd=%h done=%b%b err=%b want all 0",
                     port_req, port_we, port_addr, port_wdata, port_wstrb, if_rdata, mem_rdata,
                     if_done, mem_done, bus_err);
        end
        rst = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;
        @(negedge clk);
    endtask

    // First three entries are the directed fetch / contention / store cases.
    task automatic test_random(input int n);
        for (int it = 0; it < n; it++) begin
            logic di, dm, we, cur_if, cur_mem, xp_req, xp_id, xp_md;
            logic [31:0] ia, ma, wd;
            logic [3:0] ws;
            int rd, vd, iss_if, t_if, t_mem, last;
            case (it)
                0: begin di = 1; dm = 0; we = 0; ia = 32'h100; ma = 0; wd = 0; ws = 0; rd = 0; vd = 0; end
                1: begin di = 1; dm = 1; we = 0; ia = 32'h104; ma = 32'h2000; wd = 0; ws = 4'hF; rd = 0; vd = 0; end
                2: begin di = 0; dm = 1; we = 1; ia = 0; ma = 32'h3000; wd = 32'h1234_ABCD; ws = 4'h3; rd = 3; vd = 0; end
                default: begin
                    dm = 1'($urandom_range(0, 1));
                    di = dm ? 1'($urandom_range(0, 1)) : 1'b1;
                    we = 1'($urandom_range(0, 1));
                    ia = $urandom & 32'hFFFF_FFFC;
                    ma = $urandom & 32'hFFFF_FFFC;
                    wd = $urandom;
                    ws = 4'($urandom_range(1, 15));
                    rd = int'($urandom_range(0, 3));
                    vd = int'($urandom_range(0, 3));
                end
            endcase
            // Timeline: MEM first, IF issues the cycle after MEM's done.
            t_mem  = dm ? 3 + rd + vd : -1;
            iss_if = dm ? 4 + rd + vd : 1;
            t_if   = di ? iss_if + 2 + rd + vd : -1;
            last   = (t_if > t_mem) ? t_if : t_mem;
            ready_dly = rd; rvalid_dly = vd;
            if_req = di; if_addr = ia;
            mem_req = dm; mem_we = we; mem_addr = ma; mem_wdata = wd; mem_wstrb = ws;
            cur_if = di; cur_mem = dm;
            #1;
            total++;
            if ({if_stall, mem_stall} !== {di, dm}) begin
                bad++;
                $display("FAIL rand_stall0 it=%0d got=%b want=%b", it, {if_stall, mem_stall}, {di, dm});
            end
            for (int t = 1; t <= last + 1; t++) begin
                @(negedge clk);
                xp_id  = (t == t_if);
                xp_md  = (t == t_mem);
                xp_req = (dm && t <= 1 + rd) || (di && t >= iss_if && t <= iss_if + rd);
                total++;
                if ({port_req, if_done, mem_done, bus_err, if_stall, mem_stall} !==
                    {xp_req, xp_id, xp_md, 1'b0, cur_if && !xp_id, cur_mem && !xp_md}) begin
                    bad++;
                    $display("FAIL rand_ctl it=%0d t=%0d got req/idn/mdn/err/ist/mst=%b want=%b", it, t,
                             {port_req, if_done, mem_done, bus_err, if_stall, mem_stall},
                             {xp_req, xp_id, xp_md, 1'b0, cur_if && !xp_id, cur_mem && !xp_md});
                end
                if (dm && t <= 1 + rd) begin
                    total++;
                    if ({port_addr, port_we, port_wstrb} !== {ma, we, (we ? ws : 4'h0)} ||
                        (we && port_wdata !== wd)) begin
                        bad++;
                        $display("FAIL rand_mem_port it=%0d t=%0d got a=%h we=%b ws=%h wd=%h want a=%h we=%b ws=%h wd=%h",
                                 it, t, port_addr, port_we, port_wstrb, port_wdata, ma, we, (we ? ws : 4'h0), wd);
                    end
                end
                if (di && t >= iss_if && t <= iss_if + rd) begin
                    total++;
                    if ({port_addr, port_we, port_wstrb} !== {ia, 1'b0, 4'h0}) begin
                        bad++;
                        $display("FAIL rand_if_port it=%0d t=%0d got a=%h we=%b ws=%h want a=%h we=0 ws=0",
                                 it, t, port_addr, port_we, port_wstrb, ia);
                    end
                end
                if (xp_id) begin
                    exp_if_rdata = mem_word(ia);
                    total++;
                    if (if_rdata !== exp_if_rdata) begin
                        bad++;
                        $display("FAIL rand_if_rdata it=%0d got=%h want=%h", it, if_rdata, exp_if_rdata);
                    end
                    if_req = 1'b0; cur_if = 1'b0;
                end
                if (xp_md) begin
                    if (!we) exp_mem_rdata = mem_word(ma);
                    total++;
                    if (mem_rdata !== exp_mem_rdata) begin
                        bad++;
                        $display("FAIL rand_mem_rdata it=%0d got=%h want=%h", it, mem_rdata, exp_mem_rdata);
                    end
                    mem_req = 1'b0; cur_mem = 1'b0;
                end
            end
        end
    endtask

    // Fetch killed in WAIT; IF then re-requests 0x200, which must issue from IDLE.
    task automatic test_kill();
        ready_dly = 0; rvalid_dly = 2;
        if_req = 1'b1; if_addr = 32'h300;
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            total++;
            if ({port_req, if_done} !== {(t == 1 || t == 6), (t == 10)}) begin
                bad++;
                $display("FAIL kill_ctl t=%0d got req/done=%b want=%b", t, {port_req, if_done},
                         {(t == 1 || t == 6), (t == 10)});
            end
            if (t == 6) begin
                total++;
                if (port_addr !== 32'h200) begin
                    bad++;
                    $display("FAIL kill_refetch_addr got=%h want=00000200", port_addr);
                end
            end
            if (t == 10) begin
                exp_if_rdata = mem_word(32'h200);
                if_req = 1'b0;
            end
            total++;
            if (if_rdata !== exp_if_rdata) begin
                bad++;
                $display("FAIL kill_rdata t=%0d got=%h want=%h", t, if_rdata, exp_if_rdata);
            end
            if (t == 2) begin if_kill = 1'b1; if_addr = 32'h200; end
            if (t == 3) if_kill = 1'b0;
        end
    endtask

    // Hung port: MEM load times out with a done; a killed fetch times out silently.
    task automatic test_timeout();
        hang = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
        for (int t = 1; t <= 19; t++) begin
            @(negedge clk);
            total++;
            if ({port_req, bus_err, mem_done} !== {(t <= 15), (t == 16), (t == 17)}) begin
                bad++;
                $display("FAIL tmo_mem t=%0d got req/err/done=%b want=%b", t,
                         {port_req, bus_err, mem_done}, {(t <= 15), (t == 16), (t == 17)});
            end
            if (t == 17) begin
                exp_mem_rdata = '0;
                total++;
                if (mem_rdata !== 32'h0) begin
                    bad++;
                    $display("FAIL tmo_mem_rdata got=%h want=00000000", mem_rdata);
                end
                mem_req = 1'b0;
            end
        end
        if_req = 1'b1; if_addr = 32'h5000;
        for (int t = 1; t <= 19; t++) begin
            @(negedge clk);
            total++;
            if ({port_req, bus_err, if_done} !== {(t <= 15), (t == 16), 1'b0}) begin
                bad++;
                $display("FAIL tmo_kill t=%0d got req/err/done=%b want=%b", t,
                         {port_req, bus_err, if_done}, {(t <= 15), (t == 16), 1'b0});
            end
            if (t == 3) if_kill = 1'b1;
            if (t == 4) if_kill = 1'b0;
            if (t == 16) if_req = 1'b0;
        end
        total++;
        if (if_rdata !== exp_if_rdata) begin
            bad++;
            $display("FAIL tmo_kill_rdata got=%h want=%h", if_rdata, exp_if_rdata);
        end
        hang = 1'b0;
    endtask

    // Reset mid-WAIT clears everything without a clock edge; next fetch is minimum latency.
    task automatic test_async_reset();
        ready_dly = 0; rvalid_dly = 6;
        if_req = 1'b1; if_addr = 32'h500;
        repeat (3) @(negedge clk);
        if_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({port_req, port_we, port_addr, port_wdata, port_wstrb, if_rdata, mem_rdata,
             if_done, mem_done, bus_err, if_stall, mem_stall} !== '0) begin
            bad++;
            $display("FAIL async_reset got req=%b addr=%h ird=%h mrd=%h done=%b%b err=%b want all 0",
                     port_req, port_addr, if_rdata, mem_rdata, if_done, mem_done, bus_err);
        end
        exp_if_rdata = '0; exp_mem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ready_dly = 0; rvalid_dly = 0;
        if_req = 1'b1; if_addr = 32'h600;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            total++;
            if ({port_req, if_done} !== {(t == 1), (t == 3)}) begin
                bad++;
                $display("FAIL post_reset t=%0d got req/done=%b want=%b", t, {port_req, if_done},
                         {(t == 1), (t == 3)});
            end
            if (t == 3) begin
                total++;
                if (if_rdata !== mem_word(32'h600)) begin
                    bad++;
                    $display("FAIL post_reset_rdata got=%h want=%h", if_rdata, mem_word(32'h600));
                end
                if_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_random(40);
        test_kill();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
